// File: rtl/bitty_uart_pkg.sv
// Shared types and constants for the UART word loader.
package bitty_uart_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        WAIT_LO = 2'd0,
        WAIT_HI = 2'd1,
        HALT    = 2'd2
    } asm_state_e;

endpackage

// File: rtl/uart_word_loader_if.sv
// Byte-in / word-out handshake bundle of the UART word loader.
interface uart_word_loader_if #(
    parameter int ADDR_W = 8
);
    import bitty_uart_pkg::*;

    logic              rx_done;
    logic [7:0]        rx_data;
    logic              word_valid;
    logic              word_ready;
    logic [WORD_W-1:0] word_data;
    logic [ADDR_W-1:0] word_addr;

    // loader side: consumes bytes, produces words
    modport master (
        input  rx_done,
        input  rx_data,
        input  word_ready,
        output word_valid,
        output word_data,
        output word_addr
    );

    // environment side: byte source and instruction-memory writer
    modport slave (
        output rx_done,
        output rx_data,
        output word_ready,
        input  word_valid,
        input  word_data,
        input  word_addr
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock word FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle. dout reads 0 while the FIFO is empty.
module sync_fifo
    import bitty_uart_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign dout    = empty ? '0 : mem_q[rd_q];

    // next storage, pointers and occupancy
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_word_loader.sv
// Assembles received UART bytes into 16-bit words (low byte first), queues
// them and presents them with a valid/ready handshake and a running address.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  WAIT_LO | next byte is the low half of a word
//  WAIT_HI | low byte held, timeout running until the high byte arrives
//  HALT    | program load complete, bytes ignored until reset
module uart_word_loader
    import bitty_uart_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 4,
    parameter int          ADDR_W       = 8,
    parameter int          NUM_WORDS    = 256,
    parameter logic [15:0] BYTE_TIMEOUT = 16'd50000
) (
    input  logic               clk,
    input  logic               rst,
    uart_word_loader_if.master bus,
    output logic               overflow,
    output logic               frame_err,
    output logic               load_done
);

    localparam logic [ADDR_W:0] NUM_WORDS_C = (ADDR_W + 1)'(NUM_WORDS);

    asm_state_e        state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   pop_cnt_q, pop_cnt_d;
    logic              overflow_q, overflow_d;
    logic              frame_err_q, frame_err_d;
    logic              load_done_q, load_done_d;

    logic              lo_load;
    logic              push_req;
    logic              tmo_fire;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_dout;

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .pop   (pop),
        .din   ({bus.rx_data, lo_q}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.word_valid = ~fifo_empty;
    assign bus.word_data  = fifo_dout;
    assign bus.word_addr  = addr_q;
    assign pop            = ~fifo_empty & bus.word_ready;
    assign overflow       = overflow_q;
    assign frame_err      = frame_err_q;
    assign load_done      = load_done_q;

    // assembler state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // assembler next state; completion of the load overrides everything
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_LO: if (bus.rx_done) state_d = WAIT_HI;
            WAIT_HI: if (bus.rx_done || tmo_fire) state_d = WAIT_LO;
            HALT:    state_d = HALT;
            default: state_d = WAIT_LO;
        endcase
        if (load_done_d) begin
            state_d = HALT;
        end
    end

    // assembler outputs; a byte arriving on the timeout cycle wins
    always_comb begin
        lo_load  = 1'b0;
        push_req = 1'b0;
        tmo_fire = 1'b0;
        unique case (state_q)
            WAIT_LO: lo_load = bus.rx_done;
            WAIT_HI: begin
                push_req = bus.rx_done;
                tmo_fire = ~bus.rx_done && (tmo_q == BYTE_TIMEOUT - 16'd1);
            end
            default: ;
        endcase
    end

    // datapath: low byte, timeout, address, pop count and sticky flags
    always_comb begin
        lo_d        = lo_load ? bus.rx_data : lo_q;
        tmo_d       = tmo_q;
        if (lo_load || tmo_fire) begin
            tmo_d = '0;
        end else if (state_q == WAIT_HI && !bus.rx_done) begin
            tmo_d = tmo_q + 1'b1;
        end
        addr_d      = pop ? addr_q + 1'b1 : addr_q;
        pop_cnt_d   = pop ? pop_cnt_q + 1'b1 : pop_cnt_q;
        overflow_d  = overflow_q | (push_req & fifo_full & ~pop);
        frame_err_d = frame_err_q | tmo_fire;
        load_done_d = load_done_q | (pop && (pop_cnt_d == NUM_WORDS_C));
    end

    // datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            lo_q        <= '0;
            tmo_q       <= '0;
            addr_q      <= '0;
            pop_cnt_q   <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            load_done_q <= 1'b0;
        end else begin
            lo_q        <= lo_d;
            tmo_q       <= tmo_d;
            addr_q      <= addr_d;
            pop_cnt_q   <= pop_cnt_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            load_done_q <= load_done_d;
        end
    end

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed self-checking bench for uart_word_loader.
module tb_uart_word_loader;

    localparam logic [15:0] BT = 16'd20;

    logic clk;
    logic rst;
    logic ovf_a, ferr_a, done_a;
    logic ovf_b, ferr_b, done_b;
    int   tests;
    int   fails;

    uart_word_loader_if #(.ADDR_W(8)) bus_a ();
    uart_word_loader_if #(.ADDR_W(8)) bus_b ();

    uart_word_loader #(
        .FIFO_DEPTH   (4),
        .ADDR_W       (8),
        .NUM_WORDS    (256),
        .BYTE_TIMEOUT (BT)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_a),
        .overflow  (ovf_a),
        .frame_err (ferr_a),
        .load_done (done_a)
    );

    uart_word_loader #(
        .FIFO_DEPTH   (4),
        .ADDR_W       (8),
        .NUM_WORDS    (3),
        .BYTE_TIMEOUT (BT)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_b),
        .overflow  (ovf_b),
        .frame_err (ferr_b),
        .load_done (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input bit to_b, input logic [7:0] b);
        if (to_b) begin
            bus_b.rx_done = 1'b1;
            bus_b.rx_data = b;
        end else begin
            bus_a.rx_done = 1'b1;
            bus_a.rx_data = b;
        end
        tick();
        bus_a.rx_done = 1'b0;
        bus_b.rx_done = 1'b0;
    endtask

    task automatic send_word(input bit to_b, input logic [7:0] lo, input logic [7:0] hi);
        send_byte(to_b, lo);
        send_byte(to_b, hi);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus_a.rx_done = 1'b0; bus_a.rx_data = 8'h00; bus_a.word_ready = 1'b0;
        bus_b.rx_done = 1'b0; bus_b.rx_data = 8'h00; bus_b.word_ready = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_valid", bus_a.word_valid, 0);
        check("rst_data", bus_a.word_data, 0);
        check("rst_addr", bus_a.word_addr, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_ferr", ferr_a, 0);
        check("rst_done", done_a, 0);
        check("rst_done_b", done_b, 0);
        rst = 1'b1;

        // single word, ready high: one valid cycle
        bus_a.word_ready = 1'b1;
        send_byte(0, 8'h34);
        check("t1_valid_lo", bus_a.word_valid, 0);
        send_byte(0, 8'h12);
        check("t1_valid", bus_a.word_valid, 1);
        check("t1_data", bus_a.word_data, 32'h1234);
        check("t1_addr", bus_a.word_addr, 0);
        tick();
        check("t1_valid_after", bus_a.word_valid, 0);
        check("t1_addr_after", bus_a.word_addr, 1);

        // overflow: 5 words into a 4-deep FIFO with ready low
        do_reset();
        bus_a.word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(0, 8'h10 + 8'(i), 8'hC0 + 8'(i));
        check("t2_ovf_4", ovf_a, 0);
        check("t2_head_4", bus_a.word_data, 32'hC010);
        send_word(0, 8'h14, 8'hC4);
        check("t2_ovf_5", ovf_a, 1);
        check("t2_head_hold", bus_a.word_data, 32'hC010);
        check("t2_addr_hold", bus_a.word_addr, 0);
        bus_a.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_valid", bus_a.word_valid, 1);
            check("t2_data", bus_a.word_data, {16'h0, 8'hC0 + 8'(i), 8'h10 + 8'(i)});
            check("t2_addr", bus_a.word_addr, i);
            tick();
        end
        check("t2_empty", bus_a.word_valid, 0);
        check("t2_ovf_sticky", ovf_a, 1);

        // timeout discards the low byte
        do_reset();
        send_byte(0, 8'hAA);
        repeat (BT - 1) tick();
        check("t3_ferr_early", ferr_a, 0);
        tick();
        check("t3_ferr", ferr_a, 1);
        check("t3_no_push", bus_a.word_valid, 0);
        send_word(0, 8'h01, 8'h02);
        check("t3_valid", bus_a.word_valid, 1);
        check("t3_data", bus_a.word_data, 32'h0201);
        check("t3_addr", bus_a.word_addr, 0);
        tick();

        // high byte on the timeout cycle wins
        do_reset();
        send_byte(0, 8'h55);
        repeat (BT - 1) tick();
        send_byte(0, 8'h66);
        check("t3b_ferr", ferr_a, 0);
        check("t3b_valid", bus_a.word_valid, 1);
        check("t3b_data", bus_a.word_data, 32'h6655);
        tick();

        // full FIFO, pop and high byte in the same cycle
        do_reset();
        bus_a.word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(0, 8'h20 + 8'(i), 8'hD0 + 8'(i));
        send_byte(0, 8'h77);
        bus_a.word_ready = 1'b1;
        send_byte(0, 8'h88);
        check("t4_ovf", ovf_a, 0);
        for (int i = 1; i < 4; i++) begin
            check("t4_data", bus_a.word_data, {16'h0, 8'hD0 + 8'(i), 8'h20 + 8'(i)});
            check("t4_addr", bus_a.word_addr, i);
            tick();
        end
        check("t4_new_valid", bus_a.word_valid, 1);
        check("t4_new_data", bus_a.word_data, 32'h8877);
        check("t4_new_addr", bus_a.word_addr, 4);
        tick();
        check("t4_empty", bus_a.word_valid, 0);

        // load completion with NUM_WORDS=3
        do_reset();
        bus_a.word_ready = 1'b0;
        bus_b.word_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_word(1, 8'h40 + 8'(i), 8'h50 + 8'(i));
            check("t5_valid", bus_b.word_valid, 1);
            check("t5_data", bus_b.word_data, {16'h0, 8'h50 + 8'(i), 8'h40 + 8'(i)});
            check("t5_addr", bus_b.word_addr, i);
            tick();
            check("t5_done", done_b, (i == 2) ? 1 : 0);
        end
        send_word(1, 8'h60, 8'h61);
        check("t5_halt_valid", bus_b.word_valid, 0);
        tick();
        check("t5_halt_valid2", bus_b.word_valid, 0);
        check("t5_halt_addr", bus_b.word_addr, 3);
        check("t5_done_sticky", done_b, 1);

        // reset in the middle of a word
        do_reset();
        bus_a.word_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_word(0, 8'h30 + 8'(i), 8'hE0 + 8'(i));
        bus_a.word_ready = 1'b1;
        tick();
        bus_a.word_ready = 1'b0;
        send_byte(0, 8'h77);
        check("t6_pre_ovf", ovf_a, 1);
        check("t6_pre_addr", bus_a.word_addr, 1);
        rst = 1'b0;
        tick();
        check("t6_valid", bus_a.word_valid, 0);
        check("t6_data", bus_a.word_data, 0);
        check("t6_addr", bus_a.word_addr, 0);
        check("t6_ovf", ovf_a, 0);
        check("t6_ferr", ferr_a, 0);
        check("t6_done", done_a, 0);
        rst = 1'b1;
        bus_a.word_ready = 1'b1;
        send_word(0, 8'h9A, 8'hBC);
        check("t6_word_valid", bus_a.word_valid, 1);
        check("t6_word_data", bus_a.word_data, 32'hBC9A);
        check("t6_word_addr", bus_a.word_addr, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
